// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: shares one 16-bit ripple subtractor between NREQ
// requesters. A round-robin arbiter picks one requester at a time, and the
// request and response ports both use a valid/ready handshake.
// The FSM steps through IDLE (arbitrate and latch), EXEC (subtract and
// register the result) and RESP (hold the result until it is accepted).
// Optional feature: define SUB_ARB_SAT_EN to clamp underflowing results to 0.
module sub_share_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_diff,
    output logic                 rsp_borrow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   lat_id;
    logic [15:0]       op_a;
    logic [15:0]       op_b;

    logic [ID_W:0]     cand_sum;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic [NREQ-1:0]   grant_oh;
    logic              handshake;
    logic [15:0]       sel_a;
    logic [15:0]       sel_b;

    logic [15:0]       sub_diff;
    logic              carry;
    logic              carry_out;
    logic [15:0]       result_diff;

    // Round-robin search: first valid requester starting just above rr_ptr, wrapping.
    always_comb begin
        cand_sum    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand_sum >= (ID_W+1)'(NREQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[ID_W-1:0];
            end
        end
    end

    // One-hot grant, offered only while idle; selects the winner's operands.
    always_comb begin
        grant_oh  = grant_found ? (NREQ'(1) << grant_idx) : '0;
        req_ready = (state == IDLE) ? grant_oh : '0;
        handshake = (state == IDLE) && grant_found;
        sel_a     = req_a[16*grant_idx +: 16];
        sel_b     = req_b[16*grant_idx +: 16];
    end

    // Ripple subtractor a + ~b + 1; final carry is 1 when a >= b.
    always_comb begin
        carry    = 1'b1;
        sub_diff = '0;
        for (int i = 0; i < 16; i++) begin
            sub_diff[i] = op_a[i] ^ ~op_b[i] ^ carry;
            carry       = (op_a[i] & ~op_b[i]) | (op_a[i] & carry) | (~op_b[i] & carry);
        end
        carry_out = carry;
    end

    // Result shaping: wrap by default, or clamp to zero on underflow.
    always_comb begin
`ifdef SUB_ARB_SAT_EN
        result_diff = carry_out ? sub_diff : 16'h0000;
`else
        result_diff = sub_diff;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at the handshake, result registration in EXEC, response valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            lat_id     <= '0;
            rr_ptr     <= ID_W'(NREQ-1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_diff   <= '0;
            rsp_borrow <= 1'b0;
        end else begin
            if (handshake) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                lat_id <= grant_idx;
                rr_ptr <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_diff   <= result_diff;
                rsp_borrow <= ~carry_out;
                rsp_id     <= lat_id;
                rsp_valid  <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter (NREQ = 4).
module tb_sub_share_arbiter;

    localparam int NREQ = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [63:0]   req_a;
    logic [63:0]   req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_diff;
    logic          rsp_borrow;

    int total_checks;
    int passed_checks;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        borrow;
    } vec_t;

    vec_t vecs[8];
    int   exp_grant[5];
    logic [15:0] rr_a[4];
    logic [15:0] rr_b[4];
    logic [15:0] rr_diff[4];

    sub_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    // Drive one requester, wait (bounded) for its grant, take the handshake edge.
    task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b);
        int n;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_valid = 4'b0001 << id;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        checkOutput("grant_onehot", 32'(req_ready), 32'(4'b0001 << id));
        tick();
        req_valid = '0;
        req_a[16*id +: 16] = ~a;
        req_b[16*id +: 16] = ~b;
    endtask

    // Expected value for a table vector, including the optional clamp.
    function automatic logic [15:0] expDiff(input vec_t v);
`ifdef SUB_ARB_SAT_EN
        return v.borrow ? 16'h0000 : v.diff;
`else
        return v.diff;
`endif
    endfunction

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        req_a = '0;
        req_b = '0;

        vecs[0] = '{2, 16'd5,    16'd3,    16'd2,    1'b0};
        vecs[1] = '{1, 16'd3,    16'd5,    16'hFFFE, 1'b1};
        vecs[2] = '{0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vecs[3] = '{3, 16'h8000, 16'h8000, 16'h0000, 1'b0};
        vecs[4] = '{1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1};
        vecs[5] = '{0, 16'h1234, 16'h0234, 16'h1000, 1'b0};
        vecs[6] = '{3, 16'h0000, 16'hFFFF, 16'h0001, 1'b1};
        vecs[7] = '{2, 16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0};

        exp_grant = '{0, 1, 2, 3, 0};
        rr_a    = '{16'd1000, 16'd1010, 16'd1020, 16'd1030};
        rr_b    = '{16'd0,    16'd1,    16'd2,    16'd3};
        rr_diff = '{16'd1000, 16'd1009, 16'd1018, 16'd1027};

        // Reset state
        doReset();
        checkOutput("reset_rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("reset_rsp_id",     32'(rsp_id),     32'd0);
        checkOutput("reset_rsp_diff",   32'(rsp_diff),   32'd0);
        checkOutput("reset_rsp_borrow", 32'(rsp_borrow), 32'd0);
        checkOutput("reset_req_ready",  32'(req_ready),  32'd0);

        // Table-driven single operations
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].id, vecs[k].a, vecs[k].b);
            checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            tick();
            checkOutput("resp_rsp_valid",  32'(rsp_valid),  32'd1);
            checkOutput("resp_rsp_id",     32'(rsp_id),     32'(vecs[k].id));
            checkOutput("resp_rsp_diff",   32'(rsp_diff),   32'(expDiff(vecs[k])));
            checkOutput("resp_rsp_borrow", 32'(rsp_borrow), 32'(vecs[k].borrow));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checkOutput("drop_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Round-robin order with all requesters valid from reset
        doReset();
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = rr_a[i];
            req_b[16*i +: 16] = rr_b[i];
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int n;
            n = 0;
            while (req_ready == 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_grant[k]));
            tick();
            checkOutput("rr_exec_ready", 32'(req_ready), 32'd0);
            tick();
            checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rr_rsp_id",    32'(rsp_id),    32'(exp_grant[k]));
            checkOutput("rr_rsp_diff",  32'(rsp_diff),  32'(rr_diff[exp_grant[k]]));
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        // Back-pressure: result held while rsp_ready is low
        doReset();
        applyStimulus(1, 16'd50, 16'd20);
        req_valid = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_diff",  32'(rsp_diff),  32'd30);
            checkOutput("bp_rsp_id",    32'(rsp_id),    32'd1);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1111;
        #1;
        checkOutput("bp_next_grant", 32'(req_ready), 32'b0100);
        req_valid = '0;

        // Reset during EXEC discards the operation and restarts arbitration
        doReset();
        applyStimulus(2, 16'd9, 16'd4);
        rst_n = 1'b0;
        #2;
        checkOutput("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        checkOutput("rst_next_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("rst_no_response", 32'(rsp_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
